tube_r3_dma_ctrl: RTL and testbench
===================================

// Module: tube_r3_dma_ctrl
// PURPOSE
//  Sequences parasite-side DMA transfers through Tube register 3 (HP3/PH3) using drq/dack_b.
//  Loaded with a byte count and direction, it raises drq whenever R3 can be serviced.
//  It counts completed DMA cycles, flags terminal count, and aborts on a stalled acknowledge.
//  Sits between the Tube register file and the parasite DMA controller, clocked by the parasite clock.
// PARAMETERS
//  CNT_W    16   width of the transfer length and remaining-byte counter
//  TIMEOUT  255  clk cycles allowed from dack_b low to strobe completion before abort
// PORTS
//  clk        in   1      parasite clock; all other inputs synchronous to it
//  h_rst_b    in   1      reset, asynchronous, active-low
//  t_flag     in   1      Tube reset flag; synchronous abort/clear while high
//  en         in   1      DMA enable; low pauses between bytes
//  two_byte   in   1      R3 two-byte mode (V flag); threshold is 2 when high, else 1
//  cfg_load   in   1      1-cycle pulse: load cfg_len/cfg_dir
//  cfg_len    in   CNT_W  bytes to move
//  cfg_dir    in   1      1 = host->parasite (read HP3); 0 = parasite->host (write PH3)
//  hp3_cnt    in   2      bytes currently held in HP3 (0..2)
//  ph3_cnt    in   2      bytes currently held in PH3 (0..2)
//  dack_b     in   1      DMA acknowledge, active-low
//  p_strobe_b in   1      parasite rd_b (dir=1) or wr_b (dir=0) for the acked cycle, active-low
//  drq        out  1      DMA request to parasite
//  busy       out  1      transfer in progress (including paused)
//  tc         out  1      1-cycle pulse at terminal count
//  err        out  1      sticky: acknowledge timeout
//  remaining  out  CNT_W  bytes still to move
//  irq_done   out  1      completion interrupt request (see CONFIGURATION)
// BEHAVIOUR
//  Reset: drq=0, busy=0, tc=0, err=0, remaining=0, irq_done=0, state=IDLE.
//  States: IDLE, ARM, REQ, ACK, REL, DONE, ERR.
//  IDLE: on cfg_load with cfg_len!=0, latch len/dir, remaining<=cfg_len, err<=0, go to ARM.
//        On cfg_load with cfg_len=0, tc pulses next cycle, no drq, stay IDLE.
//  cfg_load outside IDLE is ignored.
//  ARM: ready = dir ? (hp3_cnt >= thr) : (ph3_cnt <= 2-thr), where thr = two_byte ? 2 : 1.
//       If en & ready, go to REQ; drq rises on the same registered edge.
//       If en is low, hold in ARM (paused, busy=1).
//  REQ: drq=1. When dack_b=0 is sampled, go to ACK and clear the timeout counter.
//  ACK: drq=1. Wait for p_strobe_b low then high (rising edge, sampled) while dack_b=0.
//       On that edge: remaining-=1, drq<=0, go to REL.
//       If the timeout counter reaches TIMEOUT first: drq<=0, err<=1, go to ERR.
//  REL: wait for dack_b=1. Then go to DONE if remaining==0, else ARM.
//       Minimum drq low time is 1 cycle.
//  DONE: tc=1 for exactly one cycle, busy<=0, go to IDLE.
//  ERR: busy<=0, go to IDLE. err holds until the next accepted cfg_load or t_flag.
//  Two-byte mode: one DMA cycle per byte. thr only gates when a new request may start.
//  en falling mid-byte: the current ACK/REL completes. The block then holds in ARM.
//  t_flag high, any state: next edge -> IDLE; drq=0, busy=0, remaining=0, err=0, no tc.
//  t_flag has priority over cfg_load.
//  h_rst_b low mid-transfer: all outputs return to reset values immediately (async).
//  remaining never wraps: no decrement at 0; DONE is entered from REL.
// CONFIGURATION
//  TUBE_DMA_IRQ_EN defined: irq_done is set on the DONE or ERR entry cycle.
//    It is cleared by the next accepted cfg_load, t_flag, or reset.
//  TUBE_DMA_IRQ_EN undefined: irq_done is tied 0 and its logic is absent.
// TESTING
//  1. dir=1, len=3, en=1, hp3_cnt=1, three dack/strobe cycles -> three drq pulses.
//     remaining 3->2->1->0, tc pulse after 3rd dack_b release, busy=0.
//  2. dir=0, two_byte=1, ph3_cnt=1 -> drq held 0.
//     ph3_cnt->0 -> drq=1 next edge.
//  3. len=2, en dropped during the 1st ACK -> byte 1 completes, remaining=1, drq stays 0.
//     en=1 -> drq reasserts, 2nd byte done, tc pulse.
//  4. dack_b=0 with strobe never toggling -> after TIMEOUT cycles: drq=0, err=1, no tc.
//     irq_done=1 only with TUBE_DMA_IRQ_EN.
//  5. t_flag=1 in REQ with remaining=5 -> next edge: drq=0, busy=0, remaining=0, no tc.
//     cfg_load in the same cycle is ignored.
//  6. cfg_len=0 -> tc pulse, drq never asserted.
//     cfg_load while busy -> remaining unchanged.

Source files
------------

// File: rtl/tube_r3_dma_ctrl.sv
// Tube register 3 DMA sequencer: drives drq/dack_b handshakes, counts bytes, flags tc and ack timeouts.
// Optional feature macro: TUBE_DMA_IRQ_EN adds a sticky completion interrupt on irq_done.
module tube_r3_dma_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             h_rst_b,
    input  logic             t_flag,
    input  logic             en,
    input  logic             two_byte,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             cfg_dir,
    input  logic [1:0]       hp3_cnt,
    input  logic [1:0]       ph3_cnt,
    input  logic             dack_b,
    input  logic             p_strobe_b,
    output logic             drq,
    output logic             busy,
    output logic             tc,
    output logic             err,
    output logic [CNT_W-1:0] remaining,
    output logic             irq_done
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        REQ,
        ACK,
        REL,
        DONE,
        ERR
    } state_t;

    state_t           state, state_nxt;
    logic             dir_q, dir_nxt;
    logic             strobe_low_q, strobe_low_nxt;
    logic [TW-1:0]    tmo_q, tmo_nxt;
    logic             drq_nxt, busy_nxt, tc_nxt, err_nxt;
    logic [CNT_W-1:0] rem_nxt;
    logic [1:0]       thr;
    logic             ready;

    // R3 can take another byte once enough data (read) or space (write) is present
    assign thr   = two_byte ? 2'd2 : 2'd1;
    assign ready = dir_q ? (hp3_cnt >= thr) : (ph3_cnt <= (2'd2 - thr));

    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            state        <= IDLE;
            dir_q        <= 1'b0;
            strobe_low_q <= 1'b0;
            tmo_q        <= '0;
            drq          <= 1'b0;
            busy         <= 1'b0;
            tc           <= 1'b0;
            err          <= 1'b0;
            remaining    <= '0;
        end else begin
            state        <= state_nxt;
            dir_q        <= dir_nxt;
            strobe_low_q <= strobe_low_nxt;
            tmo_q        <= tmo_nxt;
            drq          <= drq_nxt;
            busy         <= busy_nxt;
            tc           <= tc_nxt;
            err          <= err_nxt;
            remaining    <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        dir_nxt        = dir_q;
        strobe_low_nxt = strobe_low_q;
        tmo_nxt        = tmo_q;
        drq_nxt        = drq;
        busy_nxt       = busy;
        tc_nxt         = 1'b0;
        err_nxt        = err;
        rem_nxt        = remaining;

        if (t_flag) begin
            state_nxt = IDLE;
            drq_nxt   = 1'b0;
            busy_nxt  = 1'b0;
            err_nxt   = 1'b0;
            rem_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_load) begin
                        if (cfg_len != '0) begin
                            dir_nxt   = cfg_dir;
                            rem_nxt   = cfg_len;
                            err_nxt   = 1'b0;
                            busy_nxt  = 1'b1;
                            state_nxt = ARM;
                        end else begin
                            tc_nxt = 1'b1;
                        end
                    end
                end
                ARM: begin
                    if (en && ready) begin
                        drq_nxt   = 1'b1;
                        state_nxt = REQ;
                    end
                end
                REQ: begin
                    drq_nxt = 1'b1;
                    if (!dack_b) begin
                        tmo_nxt        = '0;
                        strobe_low_nxt = 1'b0;
                        state_nxt      = ACK;
                    end
                end
                // A byte completes on the strobe's rising edge while the ack is still held
                ACK: begin
                    if (!dack_b && strobe_low_q && p_strobe_b) begin
                        if (remaining != '0)
                            rem_nxt = remaining - 1'b1;
                        drq_nxt   = 1'b0;
                        state_nxt = REL;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        drq_nxt   = 1'b0;
                        err_nxt   = 1'b1;
                        state_nxt = ERR;
                    end else begin
                        tmo_nxt = tmo_q + 1'b1;
                        if (!dack_b && !p_strobe_b)
                            strobe_low_nxt = 1'b1;
                    end
                end
                REL: begin
                    if (dack_b) begin
                        if (remaining == '0) begin
                            tc_nxt    = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            state_nxt = ARM;
                        end
                    end
                end
                DONE: begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
                ERR: begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

`ifdef TUBE_DMA_IRQ_EN
    logic irq_q;
    logic irq_set;
    logic irq_clr;

    // Set on entry to DONE/ERR; an accepted load or Tube reset clears it
    assign irq_set = (state_nxt != state) && ((state_nxt == DONE) || (state_nxt == ERR));
    assign irq_clr = t_flag || ((state == IDLE) && (state_nxt == ARM));

    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b)
            irq_q <= 1'b0;
        else if (irq_clr)
            irq_q <= 1'b0;
        else if (irq_set)
            irq_q <= 1'b1;
    end

    assign irq_done = irq_q;
`else
    assign irq_done = 1'b0;
`endif

endmodule

// File: tb/tb_tube_r3_dma_ctrl.sv
// Directed self-checking bench for tube_r3_dma_ctrl with a transaction-level expectation model.
module tb_tube_r3_dma_ctrl;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 20;
`ifdef TUBE_DMA_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             h_rst_b;
    logic             t_flag;
    logic             en;
    logic             two_byte;
    logic             cfg_load;
    logic [CNT_W-1:0] cfg_len;
    logic             cfg_dir;
    logic [1:0]       hp3_cnt;
    logic [1:0]       ph3_cnt;
    logic             dack_b;
    logic             p_strobe_b;
    logic             drq;
    logic             busy;
    logic             tc;
    logic             err;
    logic [CNT_W-1:0] remaining;
    logic             irq_done;

    int total = 0;
    int bad   = 0;

    // Expectation model: bytes left, status flags, and whether drq may be high
    int m_rem   = 0;
    bit m_busy  = 1'b0;
    bit m_tc    = 1'b0;
    bit m_err   = 1'b0;
    bit m_irq   = 1'b0;
    bit drq_ok  = 1'b0;
    bit chk_on  = 1'b1;
    bit run_chk = 1'b0;

    tube_r3_dma_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .h_rst_b    (h_rst_b),
        .t_flag     (t_flag),
        .en         (en),
        .two_byte   (two_byte),
        .cfg_load   (cfg_load),
        .cfg_len    (cfg_len),
        .cfg_dir    (cfg_dir),
        .hp3_cnt    (hp3_cnt),
        .ph3_cnt    (ph3_cnt),
        .dack_b     (dack_b),
        .p_strobe_b (p_strobe_b),
        .drq        (drq),
        .busy       (busy),
        .tc         (tc),
        .err        (err),
        .remaining  (remaining),
        .irq_done   (irq_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a transfer while idle; model follows the load rules
    task automatic applyStimulus(input int len, input bit dir);
        cfg_len  = CNT_W'(len);
        cfg_dir  = dir;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        if (len != 0) begin
            m_rem  = len;
            m_busy = 1'b1;
            m_err  = 1'b0;
            m_irq  = 1'b0;
        end else begin
            m_tc = 1'b1;
            tick();
            m_tc = 1'b0;
        end
    endtask

    task automatic waitDrq(input string name);
        int n;
        n = 0;
        while (drq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput(name, drq, 1);
    endtask

    // One full DMA cycle: ack, strobe low/high, release ack
    task automatic doByte(input bit drop_en);
        dack_b = 1'b0;
        if (drop_en)
            en = 1'b0;
        tick();
        p_strobe_b = 1'b0;
        tick();
        p_strobe_b = 1'b1;
        tick();
        if (m_rem > 0)
            m_rem--;
        drq_ok = 1'b0;
        checkOutput("drq_low_after_byte", drq, 0);
        dack_b = 1'b1;
        tick();
        if (m_rem == 0) begin
            m_tc  = 1'b1;
            m_irq = IRQ_ON;
            tick();
            m_tc   = 1'b0;
            m_busy = 1'b0;
        end else begin
            drq_ok = en;
        end
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            checkOutput("remaining", remaining, m_rem);
            checkOutput("tc", tc, m_tc);
            if (!drq_ok)
                checkOutput("drq_hold", drq, 0);
            if (chk_on) begin
                checkOutput("busy", busy, m_busy);
                checkOutput("err", err, m_err);
                checkOutput("irq_done", irq_done, m_irq);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        h_rst_b    = 1'b1;
        t_flag     = 1'b0;
        en         = 1'b1;
        two_byte   = 1'b0;
        cfg_load   = 1'b0;
        cfg_len    = '0;
        cfg_dir    = 1'b0;
        hp3_cnt    = 2'd1;
        ph3_cnt    = 2'd0;
        dack_b     = 1'b1;
        p_strobe_b = 1'b1;
        #1 h_rst_b = 1'b0;
        #3;
        checkOutput("rst_drq", drq, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_tc", tc, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_remaining", remaining, 0);
        checkOutput("rst_irq", irq_done, 0);
        repeat (2) tick();
        h_rst_b = 1'b1;
        tick();
        run_chk = 1'b1;

        $display("[TB] scenario 1: read, len=3");
        applyStimulus(3, 1'b1);
        drq_ok = 1'b1;
        waitDrq("s1_drq1");
        doByte(1'b0);
        checkOutput("s1_rem_after1", remaining, 16'd2);
        waitDrq("s1_drq2");
        doByte(1'b0);
        checkOutput("s1_rem_after2", remaining, 16'd1);
        waitDrq("s1_drq3");
        doByte(1'b0);
        checkOutput("s1_rem_after3", remaining, 16'd0);
        checkOutput("s1_busy_end", busy, 0);
        checkOutput("s1_irq", irq_done, IRQ_ON);

        $display("[TB] scenario 2: write, two-byte threshold");
        two_byte = 1'b1;
        ph3_cnt  = 2'd1;
        applyStimulus(1, 1'b0);
        drq_ok = 1'b0;
        repeat (5) tick();
        checkOutput("s2_drq_gated", drq, 0);
        ph3_cnt = 2'd0;
        tick();
        drq_ok = 1'b1;
        checkOutput("s2_drq_rise", drq, 1);
        doByte(1'b0);
        two_byte = 1'b0;

        $display("[TB] scenario 3: pause mid-transfer");
        applyStimulus(2, 1'b1);
        drq_ok = 1'b1;
        waitDrq("s3_drq1");
        doByte(1'b1);
        checkOutput("s3_rem_paused", remaining, 16'd1);
        repeat (6) tick();
        checkOutput("s3_busy_paused", busy, 1);
        en     = 1'b1;
        drq_ok = 1'b1;
        waitDrq("s3_drq2");
        doByte(1'b0);

        $display("[TB] scenario 4: ack timeout");
        applyStimulus(1, 1'b1);
        drq_ok = 1'b1;
        waitDrq("s4_drq");
        dack_b = 1'b0;
        tick();
        chk_on = 1'b0;
        n = 0;
        while (err !== 1'b1 && n < TIMEOUT + 5) begin
            checkOutput("s4_drq_held", drq, 1);
            tick();
            n++;
        end
        checkOutput("s4_timeout_window", (n >= TIMEOUT - 1 && n <= TIMEOUT + 1), 1);
        drq_ok = 1'b0;
        m_err  = 1'b1;
        m_irq  = IRQ_ON;
        checkOutput("s4_drq_off", drq, 0);
        dack_b = 1'b1;
        tick();
        m_busy = 1'b0;
        chk_on = 1'b1;
        tick();
        checkOutput("s4_err_sticky", err, 1);
        t_flag = 1'b1;
        tick();
        t_flag = 1'b0;
        m_err  = 1'b0;
        m_irq  = 1'b0;
        m_rem  = 0;
        checkOutput("s4_err_cleared", err, 0);

        $display("[TB] scenario 5: t_flag abort in REQ");
        applyStimulus(5, 1'b1);
        drq_ok = 1'b1;
        waitDrq("s5_drq");
        t_flag   = 1'b1;
        cfg_load = 1'b1;
        cfg_len  = 16'd9;
        tick();
        t_flag   = 1'b0;
        cfg_load = 1'b0;
        drq_ok   = 1'b0;
        m_rem    = 0;
        m_busy   = 1'b0;
        checkOutput("s5_drq", drq, 0);
        checkOutput("s5_remaining", remaining, 16'd0);
        repeat (4) tick();

        $display("[TB] scenario 6: zero length and load while busy");
        applyStimulus(0, 1'b1);
        repeat (3) tick();
        applyStimulus(4, 1'b1);
        drq_ok = 1'b1;
        waitDrq("s6_drq");
        cfg_len  = 16'd7;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        tick();
        checkOutput("s6_rem_unchanged", remaining, 16'd4);
        doByte(1'b0);
        checkOutput("s6_rem_after_byte", remaining, 16'd3);

        $display("[TB] async reset mid-transfer");
        waitDrq("s7_drq");
        @(posedge clk);
        #3;
        h_rst_b = 1'b0;
        #1;
        m_rem  = 0;
        m_busy = 1'b0;
        drq_ok = 1'b0;
        checkOutput("s7_drq", drq, 0);
        checkOutput("s7_busy", busy, 0);
        checkOutput("s7_remaining", remaining, 0);
        tick();
        h_rst_b = 1'b1;
        repeat (3) tick();

        run_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
